uart_tx_frame: RTL and testbench

- UART transmit framer/serializer. Sits directly downstream of the TX parity generator and consumes its registered parity_bit.
- Latches a parallel word on a valid/busy handshake, then shifts out one full frame at one bit per baud_tick: start, DATA_WIDTH data bits LSB first, optional parity, stop.
- baud_tick comes from the shared baud generator. tx_out drives the UART pin.

---
 rtl/uart_tx_frame_if.sv | 24 ++
 rtl/uart_tx_frame.sv | 133 +++++++++++++
 tb/tb_uart_tx_frame.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_frame_if.sv
// Handshake and serial-line bundle for the UART transmit framer.
// The master drives the word, its parity and the baud strobe; the framer is the slave.
interface uart_tx_frame_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  baud_tick;
    logic                  data_valid;
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  parity_en;
    logic                  parity_bit;
    logic                  tx_out;
    logic                  busy;
    logic                  tx_done;

    modport master (
        output baud_tick, data_valid, parallel_data, parity_en, parity_bit,
        input  tx_out, busy, tx_done
    );

    modport slave (
        input  baud_tick, data_valid, parallel_data, parity_en, parity_bit,
        output tx_out, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, DATA_WIDTH data bits LSB first, optional parity, stop.
// Define UART_TX_TWO_STOP_EN to append a second stop bit to every frame.
module uart_tx_frame #(
    parameter int DATA_WIDTH = 8
) (
    input logic          clk,
    input logic          reset,
    uart_tx_frame_if.slave bus
);
    localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_TWO_STOP_EN
        , STOP2
`endif
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] shift_nx;
    logic [CNT_W-1:0]      cnt;
    logic                  parity_q;
    logic                  par_en_q;
    logic                  sync_first;
    logic                  tx_q;
    logic                  busy_q;
    logic                  done_q;

    assign shift_nx     = shift_q >> 1;
    assign bus.tx_out   = tx_q;
    assign bus.busy     = busy_q;
    assign bus.tx_done  = done_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            shift_q    <= '0;
            cnt        <= '0;
            parity_q   <= 1'b0;
            par_en_q   <= 1'b0;
            sync_first <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (bus.data_valid) begin
                        shift_q    <= bus.parallel_data;
                        par_en_q   <= bus.parity_en;
                        sync_first <= 1'b1;
                        busy_q     <= 1'b1;
                        state      <= SYNC;
                    end
                end
                SYNC: begin
                    // Parity generator output is valid only in the first cycle after accept.
                    sync_first <= 1'b0;
                    if (sync_first)
                        parity_q <= bus.parity_bit;
                    if (bus.baud_tick) begin
                        tx_q  <= 1'b0;
                        state <= START;
                    end
                end
                START: begin
                    if (bus.baud_tick) begin
                        cnt   <= '0;
                        tx_q  <= shift_q[0];
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (bus.baud_tick) begin
                        shift_q <= shift_nx;
                        if (cnt == CNT_LAST) begin
                            if (par_en_q) begin
                                tx_q  <= parity_q;
                                state <= PARITY;
                            end else begin
                                tx_q  <= 1'b1;
                                state <= STOP;
                            end
                        end else begin
                            cnt  <= cnt + 1'b1;
                            tx_q <= shift_nx[0];
                        end
                    end
                end
                PARITY: begin
                    if (bus.baud_tick) begin
                        tx_q  <= 1'b1;
                        state <= STOP;
                    end
                end
                STOP: begin
                    if (bus.baud_tick) begin
`ifdef UART_TX_TWO_STOP_EN
                        state  <= STOP2;
`else
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
`endif
                    end
                end
`ifdef UART_TX_TWO_STOP_EN
                STOP2: begin
                    if (bus.baud_tick) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
`endif
                default: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed and randomized bench for uart_tx_frame with a frame-level reference model.
// Also models the upstream parity generator (odd parity, registered on data_valid).
module tb_uart_tx_frame;
    localparam int W = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   period;
    int   phase;
    logic exp_q[$];

    uart_tx_frame_if #(.DATA_WIDTH(W)) bus ();

    uart_tx_frame #(.DATA_WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line values, one per bit period after SYNC.
    task automatic build(input logic [W-1:0] d, input logic pen);
        int ones;
        exp_q.delete();
        exp_q.push_back(1'b0);
        ones = 0;
        for (int i = 0; i < W; i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (pen) exp_q.push_back((ones % 2) == 0);
        exp_q.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
        exp_q.push_back(1'b1);
`endif
    endtask

    task automatic tick_cycle();
        logic             pv;
        logic [W-1:0]     pd;
        bus.baud_tick = (phase == 0);
        phase = (phase + 1 >= period) ? 0 : phase + 1;
        @(posedge clk);
        pv = bus.data_valid;
        pd = bus.parallel_data;
        #1;
        if (pv) bus.parity_bit = ~^pd;
    endtask

    task automatic offer(input logic [W-1:0] d, input logic pen);
        bus.data_valid    = 1'b1;
        bus.parallel_data = d;
        bus.parity_en     = pen;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick_cycle();
            check("idle_line", bus.tx_out, 1);
            check("idle_busy", bus.busy, 0);
            check("idle_done", bus.tx_done, 0);
        end
    endtask

    // Expects the word already offered; runs the accept edge and the whole frame.
    task automatic run_frame(input logic [W-1:0] d, input logic pen, input int reject_at,
                             input logic chain, input logic [W-1:0] nd, input logic np);
        int   ticks;
        int   len;
        logic fin;
        logic e;
        build(d, pen);
        len = exp_q.size();
        tick_cycle();
        bus.data_valid = 1'b0;
        check("accept_busy", bus.busy, 1);
        check("sync_line", bus.tx_out, 1);
        ticks = 0;
        fin = 1'b0;
        for (int c = 0; c < 4000 && !fin; c++) begin
            if (ticks == reject_at) offer(8'hFF, 1'b1);
            tick_cycle();
            bus.data_valid = 1'b0;
            if (bus.baud_tick) ticks++;
            if (ticks <= len) begin
                e = (ticks == 0) ? 1'b1 : exp_q[ticks-1];
                check("frame_line", bus.tx_out, e);
                check("frame_busy", bus.busy, 1);
                check("frame_done", bus.tx_done, 0);
            end else begin
                check("end_done", bus.tx_done, 1);
                check("end_busy", bus.busy, 0);
                check("end_line", bus.tx_out, 1);
                if (chain) offer(nd, np);
                fin = 1'b1;
            end
        end
        check("frame_finished", fin, 1);
    endtask

    initial begin
        logic [W-1:0] cd;
        logic [W-1:0] nd;
        logic         cp;
        logic         np;
        logic         ch;
        logic         pend;
        int           ticks;

        checks = 0;
        errors = 0;
        period = 3;
        phase  = 0;
        reset  = 1'b0;
        bus.baud_tick     = 1'b0;
        bus.data_valid    = 1'b0;
        bus.parallel_data = '0;
        bus.parity_en     = 1'b0;
        bus.parity_bit    = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_line", bus.tx_out, 1);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.tx_done, 0);
        reset = 1'b1;
        idle_cycles(4);

        offer(8'hA5, 1'b1);
        run_frame(8'hA5, 1'b1, -1, 1'b0, '0, 1'b0);
        idle_cycles(3);

        period = 2;
        offer(8'h3C, 1'b0);
        run_frame(8'h3C, 1'b0, -1, 1'b0, '0, 1'b0);
        idle_cycles(3);

        // 0x01 has parity 0 while the rejected 0xFF would flip the generator to 1.
        period = 4;
        offer(8'h01, 1'b1);
        run_frame(8'h01, 1'b1, 4, 1'b0, '0, 1'b0);
        idle_cycles(20);

        period = 3;
        cd = W'($urandom);
        offer(cd, 1'b1);
        run_frame(cd, 1'b1, -1, 1'b1, 8'h00, 1'b1);
        run_frame(8'h00, 1'b1, -1, 1'b0, '0, 1'b0);
        idle_cycles(3);

        period = 1;
        offer(8'h01, 1'b1);
        run_frame(8'h01, 1'b1, -1, 1'b0, '0, 1'b0);
        idle_cycles(3);

        cd   = W'($urandom);
        cp   = 1'($urandom_range(0, 1));
        pend = 1'b0;
        for (int i = 0; i < 8; i++) begin
            period = $urandom_range(1, 5);
            if (!pend) begin
                idle_cycles($urandom_range(0, 3));
                offer(cd, cp);
            end
            nd = W'($urandom);
            np = 1'($urandom_range(0, 1));
            ch = 1'($urandom_range(0, 1));
            run_frame(cd, cp, -1, ch, nd, np);
            cd   = nd;
            cp   = np;
            pend = ch;
        end
        if (pend) run_frame(cd, cp, -1, 1'b0, '0, 1'b0);
        idle_cycles(3);

        // Reset while data bit 3 (a zero for 0xA5) is on the line.
        period = 2;
        offer(8'hA5, 1'b1);
        tick_cycle();
        bus.data_valid = 1'b0;
        ticks = 0;
        for (int c = 0; c < 200 && ticks < 5; c++) begin
            tick_cycle();
            if (bus.baud_tick) ticks++;
        end
        check("pre_rst_bit3", bus.tx_out, 0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_line", bus.tx_out, 1);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_done", bus.tx_done, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        idle_cycles(10);
        offer(8'h5A, 1'b0);
        run_frame(8'h5A, 1'b0, -1, 1'b0, '0, 1'b0);
        idle_cycles(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
